hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use / redirect / memory-wait
// stall and flush generation, memory timeout flag and saturating perf counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        ResultSrcE,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TO_LIMIT = 8'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic mem_stall, load_use, redirect, stall_f_int;

    // The wait ends in the cycle memory reports ready, so that cycle already advances.
    assign mem_stall   = (MemReqM && !MemReadyM) || (state_q == MEM_WAIT && !MemReadyM);
    assign load_use    = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign redirect    = PCSrcE && !mem_stall;
    assign stall_f_int = mem_stall || (!redirect && load_use);

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst_n) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
        end
    end

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (!rst_n) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (redirect) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (MemReqM && !MemReadyM) state_d = MEM_WAIT;
            MEM_WAIT: if (MemReadyM)             state_d = RUN;
            default:                             state_d = RUN;
        endcase
    end

    always_comb begin
        to_cnt_d = 8'd0;
        if (state_q == MEM_WAIT) to_cnt_d = (to_cnt_q == 8'hFF) ? to_cnt_q : to_cnt_q + 8'd1;
        mem_timeout_d = mem_timeout_q || (to_cnt_d == TO_LIMIT && state_q == MEM_WAIT);
        stall_cnt_d = stall_cnt_q;
        if (stall_f_int && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
        flush_cnt_d = flush_cnt_q;
        if (redirect && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            to_cnt_q      <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= 16'd0;
            flush_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT = 4).
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic        mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        RdM = 5; Rs1E = 5; RegWriteM = 1;
        #3;
        checks++;
        if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0000111) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000111", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
        end
        checks++;
        if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
            errors++;
            $display("FAIL reset_fwd: got %b/%b want 00/00", ForwardAE, ForwardBE);
        end
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: got %h/%h/%b want 0/0/0", stall_cnt, flush_cnt, mem_timeout);
        end
        step();
        clear_inputs();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0000000) begin
            errors++;
            $display("FAIL idle_ctrl: got %b want 0000000", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
        end
        step();
    endtask

    task automatic test_forward();
        RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1;
        #1;
        checks++;
        if (ForwardAE !== 2'b10) begin errors++; $display("FAIL fwd_m: got %b want 10", ForwardAE); end
        RdM = 0;
        #1;
        checks++;
        if (ForwardAE !== 2'b01) begin errors++; $display("FAIL fwd_w: got %b want 01", ForwardAE); end
        RegWriteW = 0;
        #1;
        checks++;
        if (ForwardAE !== 2'b00) begin errors++; $display("FAIL fwd_none: got %b want 00", ForwardAE); end
        RdM = 9; RdW = 9; Rs2E = 9; RegWriteM = 0; RegWriteW = 1;
        #1;
        checks++;
        if (ForwardBE !== 2'b01) begin errors++; $display("FAIL fwdb_w: got %b want 01", ForwardBE); end
        RegWriteM = 1;
        #1;
        checks++;
        if (ForwardBE !== 2'b10) begin errors++; $display("FAIL fwdb_m: got %b want 10", ForwardBE); end
        RdM = 0; RdW = 0; Rs2E = 0;
        #1;
        checks++;
        if (ForwardBE !== 2'b00) begin errors++; $display("FAIL fwdb_x0: got %b want 00", ForwardBE); end
        clear_inputs();
        step();
    endtask

    task automatic test_load_use();
        ResultSrcE = 1; RdE = 7; Rs2D = 7;
        #1;
        checks++;
        if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b1100010) begin
            errors++;
            $display("FAIL load_use: got %b want 1100010", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
        end
        step();
        exp_stall++;
        clear_inputs();
        ResultSrcE = 1; RdE = 0; Rs1D = 0;
        #1;
        checks++;
        if (StallF !== 1'b0 || FlushE !== 1'b0) begin
            errors++;
            $display("FAIL load_use_x0: got %b%b want 00", StallF, FlushE);
        end
        checks++;
        if (stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, exp_stall);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_branch();
        PCSrcE = 1; ResultSrcE = 1; RdE = 3; Rs1D = 3;
        #1;
        checks++;
        if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0000110) begin
            errors++;
            $display("FAIL branch: got %b want 0000110", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
        end
        step();
        exp_flush++;
        clear_inputs();
        #1;
        checks++;
        if (flush_cnt !== 16'(exp_flush) || stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL branch_cnt: got %0d/%0d want %0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall);
        end
    endtask

    task automatic test_mem_wait();
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b1111001) begin
                errors++;
                $display("FAIL mem_wait_%0d: got %b want 1111001", i, {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
            end
            step();
            exp_stall++;
        end
        MemReadyM = 1;
        #1;
        checks++;
        if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0000110) begin
            errors++;
            $display("FAIL mem_release: got %b want 0000110", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
        end
        step();
        exp_flush++;
        clear_inputs();
        #1;
        checks++;
        if (StallF !== 1'b0 || FlushW !== 1'b0) begin
            errors++;
            $display("FAIL mem_run: got %b%b want 00", StallF, FlushW);
        end
        checks++;
        if (stall_cnt !== 16'(exp_stall) || flush_cnt !== 16'(exp_flush)) begin
            errors++;
            $display("FAIL mem_cnt: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
        step();
    endtask

    task automatic test_timeout();
        MemReqM = 1; MemReadyM = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_stall++;
            checks++;
            if (mem_timeout !== (k >= 5)) begin
                errors++;
                $display("FAIL timeout_%0d: got %b want %b", k, mem_timeout, (k >= 5));
            end
        end
        MemReadyM = 1;
        step();
        clear_inputs();
        step();
        checks++;
        if (mem_timeout !== 1'b1 || stall_cnt !== 16'(exp_stall)) begin
            errors++;
            $display("FAIL timeout_sticky: got %b/%0d want 1/%0d", mem_timeout, stall_cnt, exp_stall);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (mem_timeout !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL timeout_clear: got %b/%0d/%0d want 0/0/0", mem_timeout, stall_cnt, flush_cnt);
        end
        rst_n = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        step();
    endtask

    task automatic test_saturation_reset();
        ResultSrcE = 1; RdE = 7; Rs1D = 7;
        for (int i = 0; i < 70000; i++) step();
        clear_inputs();
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stall_sat: got %h want ffff", stall_cnt);
        end
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        step();
        step();
        checks++;
        if ({StallF, StallM, FlushW} !== 3'b111) begin
            errors++;
            $display("FAIL pre_abort: got %b want 111", {StallF, StallM, FlushW});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW} !== 7'b0000111) begin
            errors++;
            $display("FAIL abort_ctrl: got %b want 0000111", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
        end
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL abort_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        clear_inputs();
        step();
        rst_n = 1'b1;
        step();
        #1;
        checks++;
        if (StallF !== 1'b0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL post_abort_run: got %b/%0d want 0/0", StallF, stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_saturation_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
